// File: rtl/imm_decode_stage.sv
// imm_decode_stage: decode-stage sequencer for the immediate path.
//   Accepts fetched instructions over valid/ready, classifies the opcode,
//   computes the sign-extended immediate at the input and stores it with the
//   entry in a 2-entry elastic buffer (head + skid) feeding the execute stage.
// Ports:
//   clk_i, reset_i (sync, active-high), flush_i
//   in_valid_i / in_ready_o, instr_i, pc_i               (fetch side)
//   out_valid_o / out_ready_i, instr_o, pc_o, imm_o,
//   imm_src_o, has_imm_o, illegal_o                      (execute side)
// Optional feature macro: IMM_DECODE_ILLEGAL_EN (flags unrecognised opcodes
//   on illegal_o; when undefined illegal_o is tied 0 and no bit is stored).

package imm_decode_pkg;
  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    CONTROL_IMM_SRC_I_TYPE = 3'd0,
    CONTROL_IMM_SRC_S_TYPE = 3'd1,
    CONTROL_IMM_SRC_B_TYPE = 3'd2,
    CONTROL_IMM_SRC_U_TYPE = 3'd3,
    CONTROL_IMM_SRC_J_TYPE = 3'd4
  } control_imm_source_e;

  typedef struct packed {
    logic [XLEN-1:0]     instr;
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     imm;
    control_imm_source_e src;
    logic                has_imm;
`ifdef IMM_DECODE_ILLEGAL_EN
    logic                illegal;
`endif
  } entry_t;
endpackage

// Immediate generator: bit-shuffle and sign-extend per immediate format.
module imm_generator
  import imm_decode_pkg::*;
(
  input  logic [31:7]         instr_i,
  input  control_imm_source_e src_i,
  output logic [XLEN-1:0]     imm_o
);
  always_comb begin
    imm_o = '0;
    case (src_i)
      CONTROL_IMM_SRC_I_TYPE: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      CONTROL_IMM_SRC_S_TYPE: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      CONTROL_IMM_SRC_B_TYPE: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                                       instr_i[30:25], instr_i[11:8], 1'b0};
      CONTROL_IMM_SRC_U_TYPE: imm_o = {instr_i[31:12], 12'b0};
      CONTROL_IMM_SRC_J_TYPE: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                                       instr_i[20], instr_i[30:21], 1'b0};
      default:                imm_o = '0;
    endcase
  end
endmodule

module imm_decode_stage
  import imm_decode_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                flush_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [XLEN-1:0]     instr_i,
  input  logic [XLEN-1:0]     pc_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [XLEN-1:0]     instr_o,
  output logic [XLEN-1:0]     pc_o,
  output logic [XLEN-1:0]     imm_o,
  output control_imm_source_e imm_src_o,
  output logic                has_imm_o,
  output logic                illegal_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  entry_t              head_q, head_d;
  entry_t              skid_q, skid_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;

  control_imm_source_e dec_src;
  logic                dec_has_imm;
  logic                dec_known;
  logic [XLEN-1:0]     gen_imm;
  entry_t              new_entry;
  entry_t              reset_entry;
  logic                in_xfer;
  logic                out_xfer;

  // Head contents while nothing is valid.
  always_comb begin
    reset_entry       = '0;
    reset_entry.instr = NOP_INSTR;
    reset_entry.pc    = RESET_PC;
    reset_entry.src   = CONTROL_IMM_SRC_I_TYPE;
  end

  // Opcode classification at the input.
  always_comb begin
    dec_src     = CONTROL_IMM_SRC_I_TYPE;
    dec_has_imm = 1'b0;
    dec_known   = 1'b1;
    case (instr_i[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: dec_has_imm = 1'b1;
      7'b0100011: begin dec_src = CONTROL_IMM_SRC_S_TYPE; dec_has_imm = 1'b1; end
      7'b1100011: begin dec_src = CONTROL_IMM_SRC_B_TYPE; dec_has_imm = 1'b1; end
      7'b0110111, 7'b0010111: begin dec_src = CONTROL_IMM_SRC_U_TYPE; dec_has_imm = 1'b1; end
      7'b1101111: begin dec_src = CONTROL_IMM_SRC_J_TYPE; dec_has_imm = 1'b1; end
      7'b0110011: dec_has_imm = 1'b0;
      default:    dec_known   = 1'b0;
    endcase
  end

  imm_generator u_imm_gen (
    .instr_i (instr_i[31:7]),
    .src_i   (dec_src),
    .imm_o   (gen_imm)
  );

  // Entry as it will be stored; no-immediate forms store imm=0.
  always_comb begin
    new_entry         = '0;
    new_entry.instr   = instr_i;
    new_entry.pc      = pc_i;
    new_entry.src     = dec_src;
`ifdef IMM_DECODE_ILLEGAL_EN
    new_entry.illegal = ~dec_known | (instr_i[1:0] != 2'b11);
    new_entry.has_imm = dec_has_imm & ~new_entry.illegal;
`else
    new_entry.has_imm = dec_has_imm & dec_known;
`endif
    new_entry.imm     = new_entry.has_imm ? gen_imm : '0;
  end

  assign in_xfer  = in_valid_i & in_ready_q;
  assign out_xfer = out_valid_q & out_ready_i;

  // Next-state and buffer update.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          head_d  = new_entry;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_xfer && !out_xfer) begin
          skid_d  = new_entry;
          state_d = ST_FULL;
        end else if (in_xfer && out_xfer) begin
          head_d  = new_entry;
        end else if (out_xfer) begin
          head_d  = reset_entry;
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_xfer) begin
          head_d  = skid_q;
          skid_d  = reset_entry;
          state_d = ST_ONE;
        end
      end
      default: begin
        head_d  = reset_entry;
        skid_d  = reset_entry;
        state_d = ST_EMPTY;
      end
    endcase
    // Redirect drops everything, including a same-cycle accept.
    if (flush_i) begin
      head_d  = reset_entry;
      skid_d  = reset_entry;
      state_d = ST_EMPTY;
    end
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_FULL);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_EMPTY;
      head_q      <= reset_entry;
      skid_q      <= reset_entry;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign in_ready_o  = in_ready_q;
  assign instr_o     = head_q.instr;
  assign pc_o        = head_q.pc;
  assign imm_o       = head_q.imm;
  assign imm_src_o   = head_q.src;
  assign has_imm_o   = head_q.has_imm;
`ifdef IMM_DECODE_ILLEGAL_EN
  assign illegal_o   = head_q.illegal;
`else
  assign illegal_o   = 1'b0;
`endif

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed testbench for imm_decode_stage.
module tb_imm_decode_stage;
  import imm_decode_pkg::*;

  logic                clk = 1'b0;
  logic                reset_i;
  logic                flush_i;
  logic                in_valid_i;
  logic                in_ready_o;
  logic [31:0]         instr_i;
  logic [31:0]         pc_i;
  logic                out_valid_o;
  logic                out_ready_i;
  logic [31:0]         instr_o;
  logic [31:0]         pc_o;
  logic [31:0]         imm_o;
  control_imm_source_e imm_src_o;
  logic                has_imm_o;
  logic                illegal_o;

  int vectors = 0;
  int miscompares = 0;

  imm_decode_stage dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .instr_i     (instr_i),
    .pc_i        (pc_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .instr_o     (instr_o),
    .pc_o        (pc_o),
    .imm_o       (imm_o),
    .imm_src_o   (imm_src_o),
    .has_imm_o   (has_imm_o),
    .illegal_o   (illegal_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [31:0] bb_instr[4];
  logic [31:0] bb_imm[4];
  logic [2:0]  bb_src[4];
  logic        exp_illegal;

  initial begin
    bb_instr[0] = 32'h0011_2623; bb_imm[0] = 32'h0000_000C; bb_src[0] = 3'd1;
    bb_instr[1] = 32'hFE00_0EE3; bb_imm[1] = 32'hFFFF_FFFC; bb_src[1] = 3'd2;
    bb_instr[2] = 32'h1234_5037; bb_imm[2] = 32'h1234_5000; bb_src[2] = 3'd3;
    bb_instr[3] = 32'h0080_00EF; bb_imm[3] = 32'h0000_0008; bb_src[3] = 3'd4;
`ifdef IMM_DECODE_ILLEGAL_EN
    exp_illegal = 1'b1;
`else
    exp_illegal = 1'b0;
`endif

    reset_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    instr_i = '0; pc_i = '0;
    step(); step();
    reset_i = 1'b0;

    // Reset values
    check("rst_out_valid", 32'(out_valid_o), 32'd0);
    check("rst_in_ready",  32'(in_ready_o),  32'd1);
    check("rst_instr",     instr_o,          32'h0000_0013);
    check("rst_pc",        pc_o,             32'h0);
    check("rst_imm",       imm_o,            32'h0);
    check("rst_src",       32'(imm_src_o),   32'd0);
    check("rst_has_imm",   32'(has_imm_o),   32'd0);
    check("rst_illegal",   32'(illegal_o),   32'd0);

    // addi x1,x0,-1 with one-cycle latency
    out_ready_i = 1'b1;
    in_valid_i = 1'b1; instr_i = 32'hFFF0_0093; pc_i = 32'h100;
    step();
    in_valid_i = 1'b0;
    check("addi_valid",   32'(out_valid_o), 32'd1);
    check("addi_instr",   instr_o,          32'hFFF0_0093);
    check("addi_pc",      pc_o,             32'h100);
    check("addi_imm",     imm_o,            32'hFFFF_FFFF);
    check("addi_src",     32'(imm_src_o),   32'd0);
    check("addi_has_imm", 32'(has_imm_o),   32'd1);

    // Back-to-back stream at full rate
    for (int k = 0; k < 4; k++) begin
      in_valid_i = 1'b1; instr_i = bb_instr[k]; pc_i = 32'h200 + 32'(k * 4);
      step();
      check("bb_valid", 32'(out_valid_o), 32'd1);
      check("bb_ready", 32'(in_ready_o),  32'd1);
      check("bb_instr", instr_o,          bb_instr[k]);
      check("bb_pc",    pc_o,             32'h200 + 32'(k * 4));
      check("bb_imm",   imm_o,            bb_imm[k]);
      check("bb_src",   32'(imm_src_o),   32'(bb_src[k]));
    end
    in_valid_i = 1'b0;
    step();
    check("drain_valid", 32'(out_valid_o), 32'd0);
    check("drain_instr", instr_o,          32'h0000_0013);
    check("drain_imm",   imm_o,            32'h0);

    // Backpressure: A, B buffered, C held off
    out_ready_i = 1'b0;
    in_valid_i = 1'b1; instr_i = 32'h0010_0093; pc_i = 32'h300;
    step();
    check("bp_a_ready", 32'(in_ready_o), 32'd1);
    check("bp_a_instr", instr_o,         32'h0010_0093);
    instr_i = 32'h0020_0093; pc_i = 32'h304;
    step();
    check("bp_b_ready", 32'(in_ready_o), 32'd0);
    check("bp_b_instr", instr_o,         32'h0010_0093);
    instr_i = 32'h0030_0093; pc_i = 32'h308;
    step();
    check("bp_hold_ready", 32'(in_ready_o), 32'd0);
    check("bp_hold_instr", instr_o,         32'h0010_0093);
    check("bp_hold_imm",   imm_o,           32'h1);
    out_ready_i = 1'b1;
    step();
    check("bp_drain_b", instr_o,         32'h0020_0093);
    check("bp_drain_pc", pc_o,           32'h304);
    check("bp_ready_up", 32'(in_ready_o), 32'd1);
    step();
    check("bp_c_instr", instr_o, 32'h0030_0093);
    check("bp_c_imm",   imm_o,   32'h3);
    in_valid_i = 1'b0;
    step();
    check("bp_empty", 32'(out_valid_o), 32'd0);

    // Flush from FULL with a same-cycle input
    out_ready_i = 1'b0;
    in_valid_i = 1'b1; instr_i = 32'h0040_0093; pc_i = 32'h400;
    step();
    instr_i = 32'h0050_0093; pc_i = 32'h404;
    step();
    check("fl_full_ready", 32'(in_ready_o), 32'd0);
    instr_i = 32'h0060_0093; pc_i = 32'h408; flush_i = 1'b1;
    step();
    flush_i = 1'b0; in_valid_i = 1'b0;
    check("fl_valid", 32'(out_valid_o), 32'd0);
    check("fl_ready", 32'(in_ready_o),  32'd1);
    check("fl_instr", instr_o,          32'h0000_0013);
    out_ready_i = 1'b1;
    step();
    check("fl_stay_empty", 32'(out_valid_o), 32'd0);

    // R-type and unknown opcode
    in_valid_i = 1'b1; instr_i = 32'h0020_81B3; pc_i = 32'h500;
    step();
    check("add_valid",   32'(out_valid_o), 32'd1);
    check("add_has_imm", 32'(has_imm_o),   32'd0);
    check("add_imm",     imm_o,            32'h0);
    check("add_illegal", 32'(illegal_o),   32'd0);
    instr_i = 32'h0000_007F; pc_i = 32'h504;
    step();
    in_valid_i = 1'b0;
    check("ill_instr",   instr_o,          32'h0000_007F);
    check("ill_illegal", 32'(illegal_o),   32'(exp_illegal));
    check("ill_has_imm", 32'(has_imm_o),   32'd0);
    check("ill_imm",     imm_o,            32'h0);

    // Reset mid-stream
    out_ready_i = 1'b0;
    in_valid_i = 1'b1; instr_i = 32'h0070_0093; pc_i = 32'h600;
    step();
    check("mr_valid_pre", 32'(out_valid_o), 32'd1);
    reset_i = 1'b1; instr_i = 32'h0080_0093;
    step();
    reset_i = 1'b0; in_valid_i = 1'b0;
    check("mr_valid", 32'(out_valid_o), 32'd0);
    check("mr_instr", instr_o,          32'h0000_0013);
    step();
    check("mr_no_pulse", 32'(out_valid_o), 32'd0);
    check("mr_ready",    32'(in_ready_o),  32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
